stream_fork_n: RTL and testbench
================================

Name: stream_fork_n

Overview:
- Parametrised 1-to-N valid/ready stream fork: one input beat is broadcast to every output channel enabled in a per-beat mask.
- The beat retires only after every enabled channel has completed its own handshake. Channels may complete in any order and in any cycle.
- Sits between a single producer and N independent consumers.
- Successor to the fixed two-field combinational fork. Adds real handshaking, per-branch completion tracking, a configurable channel count and data width, and a completion counter.

Parameters:
- DATA_W, 8: payload width in bits.
- N_OUT, 2: number of output channels; legal range 1..16.
- CNT_W, 16: width of done_count.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: producer has a beat.
- in_data, input, DATA_W: producer payload.
- in_ready, output, 1: block accepts the beat this cycle.
- en_mask, input, N_OUT: channels that receive this beat; sampled only on input acceptance.
- out_valid, output, N_OUT: per-channel valid.
- out_data, output, N_OUT*DATA_W: per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- out_ready, input, N_OUT: per-channel ready.
- fork_status, output, 1: high while a beat is held (state HOLD).
- drop_pulse, output, 1: one-cycle pulse when a beat was accepted with an all-zero en_mask.
- done_count, output, CNT_W: count of retired beats with a non-zero mask.

Behaviour:
- Reset (rst_n low at a clk edge): all of the following take effect on that edge, and any held beat is discarded.
  - state=IDLE
  - data_q=0, mask_q=0, sent_q=0
  - out_valid=0, out_data=0
  - fork_status=0, drop_pulse=0, done_count=0
- The only registers are state (IDLE/HOLD), data_q, mask_q, sent_q[N_OUT] and done_count, plus drop_pulse.
- out_valid[i] = (state==HOLD) & mask_q[i] & ~sent_q[i]; this is combinational from registers only.
- out_data for every channel = data_q; it is zero while IDLE.
- hs[i] = out_valid[i] & out_ready[i].
- all_done = (state==HOLD) & ((sent_q | hs) == mask_q).
- in_ready = (state==IDLE) | all_done. This is a combinational path out_ready -> in_ready, which gives full throughput of 1 beat/cycle when all enabled consumers are ready.
- Accept = in_valid & in_ready.
- Transitions:
  - IDLE, accept, en_mask!=0 -> HOLD. Load data_q=in_data, mask_q=en_mask, sent_q=0.
  - IDLE, accept, en_mask==0 -> stay IDLE. Beat consumed and discarded; drop_pulse=1 next cycle.
  - HOLD, !all_done -> stay HOLD; sent_q |= hs.
  - HOLD, all_done, no accept -> IDLE; done_count += 1.
  - HOLD, all_done, accept with en_mask!=0 -> stay HOLD. Load the new beat, sent_q=0, done_count += 1.
  - HOLD, all_done, accept with en_mask==0 -> IDLE; done_count += 1; drop_pulse=1.
- Stability: once out_valid[i] rises it stays high, with data unchanged, until hs[i]. It then drops the next cycle and does not re-assert for the same beat. A channel is never delivered the same beat twice.
- en_mask changes while in HOLD are ignored until the next accept.
- Channels outside mask_q never assert valid; their out_ready is ignored.
- done_count wraps modulo 2^CNT_W without saturation.
- drop_pulse is registered and high for exactly one cycle per dropped beat.
- fork_status = (state==HOLD), registered.
- in_valid low while in HOLD has no effect; a producer withdrawing valid is legal and nothing is accepted.
- With N_OUT=1 the block degenerates to a one-entry pass-through register stage with a combinational ready path.

Test Plan:
- Reset, then in_data=8'hA5, en_mask=2'b11, both out_ready=1 -> next cycle out_valid=2'b11 and out_data=A5/A5. In that cycle in_ready=1, then state returns to IDLE and done_count=1.
- Staggered ready: mask 2'b11; out_ready[0]=1 at cycle 1 and out_ready[1]=1 at cycle 4 -> out_valid[0] drops after cycle 1, out_valid[1] holds until cycle 4, in_ready=0 for cycles 1-3, done_count=1 after cycle 4.
- Back-to-back: 4 beats 01..04, mask 2'b11, ready always high -> one beat retired per cycle, done_count=4, fork_status continuously high for 4 cycles.
- Zero mask: en_mask=0 with in_valid=1 in IDLE -> in_ready=1, no out_valid, drop_pulse=1 for one cycle, done_count unchanged.
- Mask change mid-hold: accept with mask 2'b01, then drive en_mask=2'b10 while out_ready=0 -> only out_valid[0] is asserted and the beat retires on hs[0] alone.
- Reset mid-operation: beat held with sent_q=2'b01, rst_n=0 for one edge -> out_valid=0, fork_status=0, done_count=0; the held beat is never delivered to channel 1.

Source files
------------

// File: rtl/stream_fork_n.sv
// stream_fork_n: 1-to-N valid/ready broadcast fork with per-channel completion tracking
module stream_fork_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic [N_OUT-1:0]        en_mask,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    fork_status,
  output logic                    drop_pulse,
  output logic [CNT_W-1:0]        done_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [DATA_W-1:0]  data_q;
  logic [N_OUT-1:0]   mask_q;
  logic [N_OUT-1:0]   sent_q;
  logic [N_OUT-1:0]   hs;
  logic               hold;
  logic               all_done;
  logic               accept;
  logic               load;

  // Channels still owed the held beat present valid; ready feeds back into in_ready so a fully-ready fan-out sustains one beat per cycle
  always_comb begin
    hold        = state == HOLD;
    out_valid   = {N_OUT{hold}} & mask_q & ~sent_q;
    out_data    = hold ? {N_OUT{data_q}} : '0;
    hs          = out_valid & out_ready;
    all_done    = hold && ((sent_q | hs) == mask_q);
    in_ready    = !hold || all_done;
    accept      = in_valid && in_ready;
    load        = accept && (|en_mask);
    fork_status = hold;
  end

  // Beat holding, completion tracking, drop detection and retirement counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      sent_q     <= '0;
      drop_pulse <= 1'b0;
      done_count <= '0;
    end else begin
      drop_pulse <= accept && !(|en_mask);
      if (all_done) done_count <= done_count + CNT_W'(1);
      if (load) begin
        state  <= HOLD;
        data_q <= in_data;
        mask_q <= en_mask;
        sent_q <= '0;
      end else if (accept || all_done) begin
        state <= IDLE;
      end else if (hold) begin
        sent_q <= sent_q | hs;
      end
    end
  end

endmodule

// File: tb/tb_stream_fork_n.sv
// tb_stream_fork_n: table-driven directed check of stream_fork_n (N_OUT=2, DATA_W=8)
module tb_stream_fork_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [1:0]  en_mask = '0;
  logic [1:0]  out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ready = '0;
  logic        fork_status;
  logic        drop_pulse;
  logic [15:0] done_count;

  int checks = 0;
  int errors = 0;

  stream_fork_n #(.DATA_W(8), .N_OUT(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en_mask(en_mask), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fork_status(fork_status),
    .drop_pulse(drop_pulse), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // expected fields describe outputs seen during the cycle, before the edge
  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [7:0]  id;
    logic [1:0]  em;
    logic [1:0]  ordy;
    logic        ir;
    logic [1:0]  ov;
    logic [15:0] od;
    logic        fs;
    logic        dp;
    logic [15:0] dc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] id,
                     input logic [1:0] em, input logic [1:0] ordy,
                     input logic ir, input logic [1:0] ov, input logic [15:0] od,
                     input logic fs, input logic dp, input logic [15:0] dc);
    vec_t t;
    t.rst_n = r; t.iv = iv; t.id = id; t.em = em; t.ordy = ordy;
    t.ir = ir; t.ov = ov; t.od = od; t.fs = fs; t.dp = dp; t.dc = dc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {in_ready, out_valid, out_data, fork_status, drop_pulse, done_count};
  endfunction

  initial begin
    //  rst iv  id     em     rdy    ir  ov     od        fs  dp  dc
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd0);
    add(1, 1, 8'hA5, 2'b11, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd0);
    add(1, 0, 8'h00, 2'b00, 2'b11, 1, 2'b11, 16'hA5A5, 1, 0, 16'd0);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd1);
    add(1, 1, 8'h3C, 2'b11, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd1);
    add(1, 0, 8'h00, 2'b00, 2'b01, 0, 2'b11, 16'h3C3C, 1, 0, 16'd1);
    add(1, 0, 8'h00, 2'b00, 2'b00, 0, 2'b10, 16'h3C3C, 1, 0, 16'd1);
    add(1, 0, 8'h00, 2'b00, 2'b00, 0, 2'b10, 16'h3C3C, 1, 0, 16'd1);
    add(1, 0, 8'h00, 2'b00, 2'b10, 1, 2'b10, 16'h3C3C, 1, 0, 16'd1);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd2);
    add(1, 1, 8'h01, 2'b11, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd2);
    add(1, 1, 8'h02, 2'b11, 2'b11, 1, 2'b11, 16'h0101, 1, 0, 16'd2);
    add(1, 1, 8'h03, 2'b11, 2'b11, 1, 2'b11, 16'h0202, 1, 0, 16'd3);
    add(1, 1, 8'h04, 2'b11, 2'b11, 1, 2'b11, 16'h0303, 1, 0, 16'd4);
    add(1, 0, 8'h00, 2'b00, 2'b11, 1, 2'b11, 16'h0404, 1, 0, 16'd5);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd6);
    add(1, 1, 8'h77, 2'b00, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd6);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 1, 16'd6);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd6);
    add(1, 1, 8'h5A, 2'b01, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd6);
    add(1, 0, 8'h00, 2'b10, 2'b00, 0, 2'b01, 16'h5A5A, 1, 0, 16'd6);
    add(1, 0, 8'h00, 2'b10, 2'b10, 0, 2'b01, 16'h5A5A, 1, 0, 16'd6);
    add(1, 0, 8'h00, 2'b10, 2'b01, 1, 2'b01, 16'h5A5A, 1, 0, 16'd6);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd7);
    add(1, 1, 8'h11, 2'b11, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd7);
    add(1, 1, 8'h22, 2'b00, 2'b11, 1, 2'b11, 16'h1111, 1, 0, 16'd7);
    add(1, 0, 8'h00, 2'b00, 2'b00, 1, 2'b00, 16'h0000, 0, 1, 16'd8);
    add(1, 1, 8'h33, 2'b11, 2'b00, 1, 2'b00, 16'h0000, 0, 0, 16'd8);
    add(1, 0, 8'h44, 2'b01, 2'b00, 0, 2'b11, 16'h3333, 1, 0, 16'd8);
    add(1, 1, 8'h44, 2'b01, 2'b00, 0, 2'b11, 16'h3333, 1, 0, 16'd8);
    add(1, 0, 8'h00, 2'b00, 2'b01, 0, 2'b11, 16'h3333, 1, 0, 16'd8);
    add(0, 0, 8'h00, 2'b00, 2'b00, 0, 2'b10, 16'h3333, 1, 0, 16'd8);
    add(1, 0, 8'h00, 2'b00, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd0);
    add(1, 0, 8'h00, 2'b00, 2'b11, 1, 2'b00, 16'h0000, 0, 0, 16'd0);

    repeat (2) @(posedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n = vecs[k].rst_n; in_valid = vecs[k].iv; in_data = vecs[k].id;
      en_mask = vecs[k].em; out_ready = vecs[k].ordy;
      #1;
      chk($sformatf("vec%0d", k), 64'(outs()),
          64'({vecs[k].ir, vecs[k].ov, vecs[k].od, vecs[k].fs, vecs[k].dp, vecs[k].dc}));
    end

    // single-channel beat held against a stalled consumer, then released
    @(negedge clk);
    in_valid = 1; in_data = 8'hAB; en_mask = 2'b10; out_ready = 2'b00;
    #1 chk("seq_accept", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 0; en_mask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("seq_stall%0d", i), 64'({in_ready, out_valid, out_data}), 64'({1'b0, 2'b10, 16'hABAB}));
      @(negedge clk);
    end
    out_ready = 2'b01;
    #1 chk("seq_ch0_ignored", 64'({in_ready, out_valid}), 64'({1'b0, 2'b10}));
    @(negedge clk);
    out_ready = 2'b10;
    #1 chk("seq_release", 64'({in_ready, out_valid}), 64'({1'b1, 2'b10}));
    @(negedge clk);
    out_ready = 2'b00;
    #1 chk("seq_retired", 64'({out_valid, fork_status, done_count}), 64'({2'b00, 1'b0, 16'd1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
